uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Synchronous show-ahead FIFO that buffers bytes from the host/bus side and feeds Uart_Transmitter through its valid/ready handshake. It sits directly upstream of the transmitter, in the same i_u_clk domain. It absorbs bursts while the transmitter holds ready low for a character frame. It also provides fill-level, threshold and sticky overflow status for software.

Parameters:
P_UART_DATA_WIDTH, `UART_DATA_WIDTH (8), width of each stored word; must equal the transmitter's data width.
P_FIFO_ADDR_WIDTH, 4, log2 of depth; depth = 2**P_FIFO_ADDR_WIDTH (16).
P_ALMOST_FULL, 12, o_almost_full asserts when count >= this value; legal range 1..depth.

Ports:
i_u_clk  input  1  clock, same as transmitter.
i_u_rst  input  1  reset, asynchronous, active-high.
i_flush  input  1  synchronous flush; empties the FIFO.
i_wr_data  input  P_UART_DATA_WIDTH  word to enqueue.
i_wr_valid  input  1  write request.
o_wr_ready  output  1  FIFO not full.
o_uart_tx_data  output  P_UART_DATA_WIDTH  head word, to transmitter i_uart_tx_data.
o_uart_tx_valid  output  1  FIFO not empty, to transmitter i_uart_tx_valid.
i_uart_tx_ready  input  1  from transmitter o_uart_tx_ready.
o_count  output  P_FIFO_ADDR_WIDTH+1  current occupancy, 0..depth.
o_empty  output  1  count == 0.
o_full  output  1  count == depth.
o_almost_full  output  1  count >= P_ALMOST_FULL.
o_overflow  output  1  sticky; set when a write is attempted while full.
i_clr_err  input  1  clears o_overflow.

Behaviour:
- Reset (async, i_u_rst=1):
  - Read and write pointers = 0; count = 0.
  - o_empty=1, o_full=0, o_almost_full=0, o_overflow=0.
  - o_wr_ready=1, o_uart_tx_valid=0, o_uart_tx_data=0 (storage is not reset; the data output is masked to 0 while empty).
  - Reset mid-burst discards all content. The transmitter is reset by the same signal, so no partial frame survives.
- Pointers: P_FIFO_ADDR_WIDTH+1 bits. The MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: address bits are equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*depth.
- Write fire: wr_fire = i_wr_valid & o_wr_ready. Stores i_wr_data at mem[wr_ptr] on the clock edge and increments wr_ptr.
- Read fire: rd_fire = o_uart_tx_valid & i_uart_tx_ready. Increments rd_ptr; no other action is needed.
- Show-ahead: o_uart_tx_data = mem[rd_ptr[addr]] (combinational read of registered storage). It is valid whenever o_uart_tx_valid=1.
- Latency:
  - A word written at edge N is presented with o_uart_tx_valid=1 after edge N (visible in cycle N+1).
  - Write-to-transmitter-accept takes a minimum of 1 cycle.
- Flags: o_empty, o_full, o_almost_full and o_count are registered, updated on every edge from the next count value.
  - o_wr_ready = ~o_full.
  - o_uart_tx_valid = ~o_empty.
- Count: count_next = count + wr_fire - rd_fire.
  - Simultaneous fire leaves count unchanged.
  - Both pointers advance together.
- Boundaries:
  - Full and i_wr_valid=1: write is rejected (o_wr_ready=0 that cycle) even if a read fires in the same cycle. The freed slot accepts a write on the next cycle.
  - Empty and write: no read is possible in that cycle, because valid is low.
  - Overflow: i_wr_valid=1 while o_full=1 sets o_overflow on the next edge. It holds until i_clr_err=1.
  - If i_clr_err and a new overflow occur in the same cycle, set wins.
- Flush (i_flush=1):
  - Next edge: pointers=0, count=0, flags as at reset.
  - Any write or read in the same cycle is ignored.
  - o_overflow is NOT cleared by flush.
- Handshake rules:
  - Once o_uart_tx_valid=1, head data stays stable until rd_fire or flush.
  - The transmitter's registered ready drops one cycle after acceptance. A second rd_fire cannot occur before the frame completes.
- No combinational path from i_uart_tx_ready to o_wr_ready, or from i_wr_valid to o_uart_tx_valid.

Test Plan:
- Reset, then write 0xA5 at cycle 0 -> cycle 1: o_uart_tx_valid=1, o_uart_tx_data=0xA5, o_count=1. With i_uart_tx_ready=1, count returns to 0 and o_empty=1 after the accept edge.
- Write 16 words 0x00..0x0F with i_uart_tx_ready=0 -> o_almost_full asserts after the 12th, o_full=1 and o_wr_ready=0 after the 16th. A 17th write sets o_overflow; data reads back 0x00..0x0F in order.
- Full FIFO, i_wr_valid=1 and rd_fire in the same cycle -> write rejected, count 15. The next-cycle write is accepted, count 16.
- Connect to Uart_Transmitter (8N1), write 0x55,0x3C back-to-back -> line shows start,10101010,stop, then start,00111100,stop. The second word is dequeued only when the transmitter's ready returns high.
- Write 5 words, assert i_flush with a simultaneous write -> next cycle o_count=0, o_empty=1, o_overflow unchanged. i_clr_err clears o_overflow.
- 40 writes/reads with random valid/ready across pointer wrap -> data order preserved and o_count always equals writes minus reads.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - show-ahead byte FIFO feeding the UART transmitter
// Registered count and flags; the head word is read combinationally and masked to zero while empty.
module uart_tx_fifo #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_FIFO_ADDR_WIDTH = 4,
  parameter int P_ALMOST_FULL     = 12
) (
  input  logic                         i_u_clk,
  input  logic                         i_u_rst,
  input  logic                         i_flush,
  input  logic [P_UART_DATA_WIDTH-1:0] i_wr_data,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  output logic [P_UART_DATA_WIDTH-1:0] o_uart_tx_data,
  output logic                         o_uart_tx_valid,
  input  logic                         i_uart_tx_ready,
  output logic [P_FIFO_ADDR_WIDTH:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_full,
  output logic                         o_overflow,
  input  logic                         i_clr_err
);

  localparam int AW = P_FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_LVL = P_ALMOST_FULL[AW:0];

  logic [P_UART_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [AW:0] count_next;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        overflow;
  logic        wr_fire;
  logic        rd_fire;

  // Flush suppresses both fires so pointers and storage see no traffic that cycle.
  assign wr_fire = i_wr_valid & ~full & ~i_flush;
  assign rd_fire = ~empty & i_uart_tx_ready & ~i_flush;

  always_comb begin
    count_next = count;
    if (i_flush) begin
      count_next = '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge i_u_clk or posedge i_u_rst) begin
    if (i_u_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
        if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == DEPTH_CNT);
      almost_full <= (count_next >= AF_LVL);
    end
  end

  // Sticky error: a new overflow takes priority over a same-cycle clear.
  always_ff @(posedge i_u_clk or posedge i_u_rst) begin
    if (i_u_rst) begin
      overflow <= 1'b0;
    end else if (i_wr_valid && full) begin
      overflow <= 1'b1;
    end else if (i_clr_err) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_u_clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_uart_tx_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_uart_tx_valid = ~empty;
  assign o_wr_ready      = ~full;
  assign o_count         = count;
  assign o_empty         = empty;
  assign o_full          = full;
  assign o_almost_full   = almost_full;
  assign o_overflow      = overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
// Stimulus process predicts occupancy and pushes accepted words; a negedge monitor checks flags and pops on reads.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       clr_err = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .P_UART_DATA_WIDTH(8),
    .P_FIFO_ADDR_WIDTH(4),
    .P_ALMOST_FULL(12)
  ) dut (
    .i_u_clk(clk),
    .i_u_rst(rst),
    .i_flush(flush),
    .i_wr_data(wr_data),
    .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready),
    .o_uart_tx_data(tx_data),
    .o_uart_tx_valid(tx_valid),
    .i_uart_tx_ready(tx_ready),
    .o_count(count),
    .o_empty(empty),
    .o_full(full),
    .o_almost_full(almost_full),
    .o_overflow(overflow),
    .i_clr_err(clr_err)
  );

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  // Reference model: a queue of words the FIFO should hold, plus committed occupancy.
  logic [7:0] exp_q[$];
  int occ = 0;
  int occ_nxt = 0;
  bit ovf = 0;
  bit ovf_nxt = 0;
  bit flush_pend = 0;
  int writes = 0;
  int reads = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit wv, input logic [7:0] wd, input bit rdy, input bit fl, input bit clr);
    bit wacc;
    bit racc;
    @(posedge clk);
    #1;
    occ = occ_nxt;
    ovf = ovf_nxt;
    if (flush_pend) exp_q.delete();
    wr_valid = wv;
    wr_data  = wd;
    tx_ready = rdy;
    flush    = fl;
    clr_err  = clr;
    wacc = wv && (occ < 16) && !fl;
    racc = rdy && (occ > 0) && !fl;
    if (wacc) begin
      exp_q.push_back(wd);
      writes++;
    end
    if (racc) reads++;
    occ_nxt = fl ? 0 : occ + int'(wacc) - int'(racc);
    ovf_nxt = (wv && occ == 16) ? 1'b1 : (clr ? 1'b0 : ovf);
    flush_pend = fl;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", int'(count), occ);
      chk("valid", int'(tx_valid), int'(occ != 0));
      chk("wr_ready", int'(wr_ready), int'(occ != 16));
      chk("empty", int'(empty), int'(occ == 0));
      chk("full", int'(full), int'(occ == 16));
      chk("almost_full", int'(almost_full), int'(occ >= 12));
      chk("overflow", int'(overflow), int'(ovf));
      if (!tx_valid) begin
        chk("data_masked", int'(tx_data), 0);
      end else if (tx_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 1, 0);
        end else begin
          chk("head_data", int'(tx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_data", int'(tx_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Single word, then accepted by a ready transmitter.
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Fill to full, overflow attempt, drain in order.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 8'h00, 1, 0, 0);

    // Full with a same-cycle write and read: write rejected, next write lands.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    step(1, 8'h99, 1, 0, 0);
    step(1, 8'h9A, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Flush with a simultaneous write keeps overflow; then clear it.
    step(1, 8'h77, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 8'h6F, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // Random traffic across pointer wrap, writer-heavy then reader-heavy.
    for (int i = 0; i < 150; i++)
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0,
           ($urandom % 60) == 0, ($urandom % 12) == 0);
    for (int i = 0; i < 150; i++)
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) != 0,
           ($urandom % 60) == 0, ($urandom % 12) == 0);

    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_occ", occ, 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
